uart_word_sched: RTL and testbench
==================================

Name: uart_word_sched

Overview:
- Controller that sequences the UART transmitter (`uarttx`) to emit one 32-bit debug word as 8 uppercase hex ASCII characters, MSB nibble first, followed by CR (0x0D) and LF (0x0A).
- Sits between the board-level debug mux (showdata / check / memdata selection) and `uarttx`. It replaces the free-running `wrsig=1` hookup with a proper per-character handshake.
- Word capture is either on an explicit strobe or on an internal periodic trigger.

Parameters:
- AUTO_PERIOD, 0: clock cycles between automatic captures; 0 disables auto mode.
- START_TO, 1023: cycles to wait for `tx_idle` to fall after a `tx_wrsig` pulse before re-issuing it.
- MAX_RETRY, 3: re-issues per character before the character is abandoned and `err` is set.

Ports:
- clk, in, 1: system clock (CLK100MHZ domain; same clock as `uarttx`).
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle request to send `word_in`.
- word_in, in, 32: word to transmit; sampled on an accepted trigger.
- auto_en, in, 1: enables the periodic trigger; ignored when AUTO_PERIOD=0.
- tx_idle, in, 1: `uarttx` idle flag; 1 means ready.
- tx_data, out, 8: character to `uarttx` datain.
- tx_wrsig, out, 1: one-cycle write strobe to `uarttx`.
- busy, out, 1: 1 from trigger acceptance until the cycle after `done`.
- done, out, 1: one-cycle pulse after LF completes or after an abandon.
- dropped, out, 1: sticky; set by a trigger arriving while busy. Cleared only by reset.
- err, out, 1: sticky; set on character abandon. Cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, tx_data=0x00, tx_wrsig=0, busy=0, done=0, dropped=0, err=0.
  - Character index=0, retry count=0, timeout count=0, auto counter=0.
- Trigger:
  - trig = start | auto_tick.
  - auto_tick is a one-cycle pulse when the auto counter reaches AUTO_PERIOD-1 with auto_en=1. The counter then wraps to 0.
  - The counter holds at 0 while auto_en=0.
  - If start and auto_tick coincide, they count as one trigger.
- FSM states: IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_IDLE, NEXT, FIN.
- IDLE:
  - trig=1 latches word_in into the shadow register, sets index=0, busy=1, and goes to LOAD next cycle.
- LOAD:
  - tx_data = char(index).
  - Go to STROBE only when tx_idle=1; otherwise hold in LOAD.
- STROBE:
  - tx_wrsig=1 for exactly this cycle.
  - Clear the timeout count; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_idle=0 goes to WAIT_IDLE.
  - A timeout count reaching START_TO with retry<MAX_RETRY increments retry and goes to STROBE.
  - Timeout with retry=MAX_RETRY sets err and goes to FIN (the rest of the word is abandoned).
- WAIT_IDLE:
  - tx_idle=1 goes to NEXT. There is no timeout in this state.
- NEXT:
  - Clear retry. index=9 goes to FIN; otherwise index+1 and go to LOAD.
- FIN:
  - done=1 for one cycle; then go to IDLE.
  - busy stays 1 in FIN and drops in the following IDLE cycle.
- Character map:
  - index 0..7 selects nibble word[31-4*index -: 4].
  - Nibbles 0..9 map to 0x30..0x39; nibbles A..F map to 0x41..0x46.
  - index 8 = 0x0D, index 9 = 0x0A.
- tx_data is registered and stays stable from LOAD until the next LOAD.
- Any trig while state≠IDLE (including FIN) sets dropped. The request is not queued.
- The shadow word is never updated mid-transmission, even if word_in changes.
- Reset mid-transmission aborts immediately. tx_wrsig goes to 0 asynchronously. No partial character is re-sent.
- Width rules:
  - Timeout counter width is $clog2(START_TO+1).
  - Auto counter width is $clog2(AUTO_PERIOD) (minimum 1).
  - Retry counter width is $clog2(MAX_RETRY+1).

Decomposition:
- Shared package `debug_pkg`:
  - State enum `uws_state_t`.
  - Constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, `CHARS_PER_WORD`=10.
  - Function `nib2ascii(logic [3:0]) -> logic [7:0]`.
- One natural sub-module, `auto_trigger`: the parameterised period counter producing auto_tick. Everything else stays in one always_ff plus one always_comb.

Test Plan:
- start with word_in=0x1234ABCD and a bench `uarttx` model (idle low 20 cycles after each wrsig) -> tx_data sequence 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A. Exactly 10 wrsig pulses, done once, busy falls the cycle after done, err=0, dropped=0.
- Word 0x00000000 then 0xFFFFFFFF back-to-back (second start one cycle after done) -> eight 0x30 + CR/LF, then eight 0x46 + CR/LF.
- Second start issued during char 3 -> dropped=1 and stays 1. The first word completes unaltered. No second transmission occurs.
- Model that ignores wrsig forever, with START_TO=15 and MAX_RETRY=3 -> 4 wrsig pulses spaced 16+ cycles apart for char 0, then err=1, one done pulse, return to IDLE.
- AUTO_PERIOD=2000, auto_en=1, word_in changed mid-send -> a capture every 2000 cycles. Each transmission reflects the word at its trigger cycle. A tick landing while busy sets dropped.
- rst_n asserted during WAIT_IDLE of char 5 -> all outputs at reset values immediately. After release, a fresh start transmits a full 10 characters starting at index 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types, constants and ASCII helpers for the UART debug-word scheduler.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_BUSY,
    WAIT_IDLE,
    NEXT,
    FIN
  } uws_state_t;

  localparam logic [7:0]  ASCII_CR       = 8'h0D;
  localparam logic [7:0]  ASCII_LF       = 8'h0A;
  localparam int unsigned CHARS_PER_WORD = 10;
  localparam int unsigned IDX_W          = 4;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character at position idx: eight hex digits MSB first, then CR, LF.
  function automatic logic [7:0] word_char(input logic [31:0] w, input logic [IDX_W-1:0] idx);
    logic [31:0] sh;
    sh = w << {idx[2:0], 2'b00};
    if (idx == IDX_W'(CHARS_PER_WORD - 2)) return ASCII_CR;
    if (idx == IDX_W'(CHARS_PER_WORD - 1)) return ASCII_LF;
    return nib2ascii(sh[31:28]);
  endfunction

endpackage

// File: rtl/uart_word_sched_if.sv
// Request side and uarttx-facing signals of the debug-word scheduler.
interface uart_word_sched_if;
  logic        start;
  logic [31:0] word_in;
  logic        auto_en;
  logic        tx_idle;
  logic [7:0]  tx_data;
  logic        tx_wrsig;
  logic        busy;
  logic        done;
  logic        dropped;
  logic        err;

  modport master (
    output start, word_in, auto_en, tx_idle,
    input  tx_data, tx_wrsig, busy, done, dropped, err
  );

  modport slave (
    input  start, word_in, auto_en, tx_idle,
    output tx_data, tx_wrsig, busy, done, dropped, err
  );
endinterface

// File: rtl/uart_word_sched_auto_trigger.sv
// Periodic capture trigger; tick_o is high for the one cycle the counter sits at PERIOD-1.
module auto_trigger #(
  parameter int unsigned PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned LAST_I = (PERIOD > 0) ? PERIOD - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Tick is computed from the next count so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if ((PERIOD != 0) && en_i) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tick_d = (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_word_sched.sv
// Sequences uarttx through one 32-bit word as 8 hex chars + CR/LF with per-char handshake and retry.
module uart_word_sched
  import debug_pkg::*;
#(
  parameter int unsigned AUTO_PERIOD = 0,
  parameter int unsigned START_TO    = 1023,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic              clk,
  input logic              rst_n,
  uart_word_sched_if.slave uws
);

  localparam int unsigned TO_W = (START_TO > 0) ? $clog2(START_TO + 1) : 1;
  localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  uws_state_t       state_q, state_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             wrsig_q, wrsig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;
  logic             err_q, err_d;
  logic             auto_tick;
  logic             trig;

  auto_trigger #(.PERIOD(AUTO_PERIOD)) u_auto_trigger (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (uws.auto_en),
    .tick_o (auto_tick)
  );

  assign trig = uws.start | auto_tick;

  // Strobe and done are raised on entry so each is high exactly while in STROBE / FIN.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    to_d      = to_q;
    tx_data_d = tx_data_q;
    wrsig_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dropped_d = dropped_q | (trig & (state_q != IDLE));
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          shadow_d = uws.word_in;
          idx_d    = '0;
          retry_d  = '0;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = word_char(shadow_q, idx_q);
        if (uws.tx_idle) begin
          wrsig_d = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        to_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!uws.tx_idle) begin
          state_d = WAIT_IDLE;
        end else if (to_q == TO_W'(START_TO)) begin
          if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d = retry_q + RT_W'(1);
            wrsig_d = 1'b1;
            state_d = STROBE;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (uws.tx_idle) state_d = NEXT;
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == IDX_W'(CHARS_PER_WORD - 1)) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      to_q      <= '0;
      tx_data_q <= 8'h00;
      wrsig_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      to_q      <= to_d;
      tx_data_q <= tx_data_d;
      wrsig_q   <= wrsig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      err_q     <= err_d;
    end
  end

  assign uws.tx_data  = tx_data_q;
  assign uws.tx_wrsig = wrsig_q;
  assign uws.busy     = busy_q;
  assign uws.done     = done_q;
  assign uws.dropped  = dropped_q;
  assign uws.err      = err_q;

endmodule

// File: tb/tb_uart_word_sched.sv
// Scoreboard bench for uart_word_sched with a behavioural uarttx (idle low 20 cycles per write).
module tb_uart_word_sched;

  localparam int unsigned AUTO_P = 2000;
  localparam int unsigned TO     = 15;
  localparam int unsigned MR     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_word_sched_if bus();

  uart_word_sched #(.AUTO_PERIOD(AUTO_P), .START_TO(TO), .MAX_RETRY(MR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .uws   (bus)
  );

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         mcnt = 0;
  bit         model_ignore = 1'b0;
  logic [7:0] sb[$];
  int         wr_times[$];
  logic [7:0] exp_c;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_char(input logic [31:0] w, input int i);
    logic [3:0] n;
    if (i == 8) return 8'h0D;
    if (i == 9) return 8'h0A;
    n = w[31-4*i -: 4];
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 10; i++) sb.push_back(exp_char(w, i));
  endtask

  // Scoreboard pop on every write strobe, plus the uarttx model.
  always @(negedge clk) begin
    if (bus.tx_wrsig === 1'b1) begin
      wr_cnt++;
      wr_times.push_back(cyc);
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL wrsig_unexpected: tx_data=%h with no character expected", bus.tx_data);
      end else begin
        exp_c = sb.pop_front();
        if (bus.tx_data !== exp_c) begin
          tests_failed++;
          $display("FAIL tx_char: got %h expected %h", bus.tx_data, exp_c);
        end
      end
    end
    if (bus.done === 1'b1) done_cnt++;
    if (model_ignore) begin
      mcnt = 0;
      bus.tx_idle = 1'b1;
    end else if (bus.tx_wrsig === 1'b1) begin
      mcnt = 20;
      bus.tx_idle = 1'b0;
    end else begin
      if (mcnt > 0) mcnt--;
      bus.tx_idle = (mcnt == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.auto_en = 1'b0;
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start(input logic [31:0] w, input bit push);
    bus.word_in = w;
    bus.start = 1'b1;
    if (push) push_word(w);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_rise(input int budget, output bit ok, output int t);
    logic prev;
    ok = 1'b0;
    t = 0;
    prev = bus.busy;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!prev && bus.busy === 1'b1) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      prev = bus.busy;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.tx_data, bus.tx_wrsig} !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_tx: got data=%h wrsig=%b expected 00/0", bus.tx_data, bus.tx_wrsig);
    end
    tests_run++;
    if ({bus.busy, bus.done, bus.dropped, bus.err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/done/dropped/err=%b expected 0000",
               {bus.busy, bus.done, bus.dropped, bus.err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int wr0, d0;
    bit ok;
    wr0 = wr_cnt;
    d0 = done_cnt;
    pulse_start(32'h1234ABCD, 1'b1);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy_rise: got %b expected 1", bus.busy);
    end
    wait_done(1000, ok);
    tests_run++;
    if (!ok || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done: got done_seen=%b busy=%b expected 1/1", ok, bus.busy);
    end
    step();
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_busy_fall: got busy/done=%b expected 00", {bus.busy, bus.done});
    end
    tests_run++;
    if (wr_cnt - wr0 != 10 || done_cnt - d0 != 1 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_counts: got wrsig=%0d done=%0d left=%0d expected 10/1/0",
               wr_cnt - wr0, done_cnt - d0, sb.size());
    end
    tests_run++;
    if ({bus.err, bus.dropped} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_flags: got err/dropped=%b expected 00", {bus.err, bus.dropped});
    end
  endtask

  task automatic test_back_to_back();
    int wr0;
    bit ok;
    wr0 = wr_cnt;
    pulse_start(32'h00000000, 1'b1);
    wait_done(1000, ok);
    step();
    pulse_start(32'hFFFFFFFF, 1'b1);
    tests_run++;
    if (!ok || bus.busy !== 1'b1 || bus.dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: got done1=%b busy=%b dropped=%b expected 1/1/0", ok, bus.busy, bus.dropped);
    end
    wait_done(1000, ok);
    step();
    tests_run++;
    if (!ok || wr_cnt - wr0 != 20 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_counts: got done2=%b wrsig=%0d left=%0d expected 1/20/0", ok, wr_cnt - wr0, sb.size());
    end
  endtask

  task automatic test_dropped();
    int wr0;
    bit ok;
    wr0 = wr_cnt;
    pulse_start(32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 500 && (wr_cnt - wr0) < 4; i++) step();
    bus.word_in = 32'h11111111;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests_run++;
    if (bus.dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL dropped_set: got %b expected 1", bus.dropped);
    end
    wait_done(1000, ok);
    step();
    tests_run++;
    if (!ok || wr_cnt - wr0 != 10 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL dropped_word: got done=%b wrsig=%0d left=%0d expected 1/10/0", ok, wr_cnt - wr0, sb.size());
    end
    repeat (60) step();
    tests_run++;
    if (wr_cnt - wr0 != 10 || bus.busy !== 1'b0 || bus.dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL dropped_noqueue: got wrsig=%0d busy=%b dropped=%b expected 10/0/1",
               wr_cnt - wr0, bus.busy, bus.dropped);
    end
  endtask

  task automatic test_timeout();
    int wr0, d0;
    bit ok;
    do_reset();
    model_ignore = 1'b1;
    step();
    wr_times.delete();
    wr0 = wr_cnt;
    d0 = done_cnt;
    pulse_start(32'hC0FFEE00, 1'b0);
    repeat (4) sb.push_back(8'h43);
    wait_done(300, ok);
    tests_run++;
    if (!ok || bus.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_err: got done=%b err=%b expected 1/1", ok, bus.err);
    end
    step();
    tests_run++;
    if (wr_cnt - wr0 != 4 || done_cnt - d0 != 1 || bus.busy !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL timeout_counts: got wrsig=%0d done=%0d busy=%b left=%0d expected 4/1/0/0",
               wr_cnt - wr0, done_cnt - d0, bus.busy, sb.size());
    end
    for (int i = 1; i < wr_times.size(); i++) begin
      tests_run++;
      if (wr_times[i] - wr_times[i-1] < 16) begin
        tests_failed++;
        $display("FAIL timeout_gap%0d: got %0d cycles expected >=16", i, wr_times[i] - wr_times[i-1]);
      end
    end
    repeat (40) step();
    tests_run++;
    if (wr_cnt - wr0 != 4 || bus.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_quiet: got wrsig=%0d err=%b expected 4/1", wr_cnt - wr0, bus.err);
    end
    model_ignore = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    int wr0;
    bit ok;
    wr0 = wr_cnt;
    pulse_start(32'h89ABCDEF, 1'b1);
    for (int i = 0; i < 500 && (wr_cnt - wr0) < 6; i++) step();
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.tx_data, bus.tx_wrsig, bus.busy, bus.done, bus.dropped, bus.err} !== 13'h0000) begin
      tests_failed++;
      $display("FAIL reset_async: got data=%h wrsig/busy/done/dropped/err=%b expected 00/00000",
               bus.tx_data, {bus.tx_wrsig, bus.busy, bus.done, bus.dropped, bus.err});
    end
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    wr0 = wr_cnt;
    pulse_start(32'h5A5A0F0F, 1'b1);
    wait_done(1000, ok);
    step();
    tests_run++;
    if (!ok || wr_cnt - wr0 != 10 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_resend: got done=%b wrsig=%0d left=%0d expected 1/10/0", ok, wr_cnt - wr0, sb.size());
    end
  endtask

  task automatic test_auto();
    int t_en, r1, r2, r3;
    bit ok, ok_d;
    do_reset();
    bus.word_in = 32'hA1B2C3D4;
    bus.auto_en = 1'b1;
    t_en = cyc;
    wait_rise(2100, ok, r1);
    push_word(bus.word_in);
    tests_run++;
    if (!ok || r1 - t_en != 2000) begin
      tests_failed++;
      $display("FAIL auto_first: got seen=%b after %0d cycles expected 1/2000", ok, r1 - t_en);
    end
    repeat (50) step();
    bus.word_in = 32'h0F1E2D3C;
    wait_done(1000, ok_d);
    wait_rise(2100, ok, r2);
    push_word(bus.word_in);
    tests_run++;
    if (!ok || !ok_d || r2 - r1 != 2000) begin
      tests_failed++;
      $display("FAIL auto_period: got seen=%b done=%b spacing=%0d expected 1/1/2000", ok, ok_d, r2 - r1);
    end
    repeat (50) step();
    bus.word_in = 32'h9876FEDC;
    wait_done(1000, ok_d);
    step();
    while (cyc < r2 + 1900) step();
    tests_run++;
    if (bus.dropped !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL auto_pre: got dropped=%b busy=%b expected 0/0", bus.dropped, bus.busy);
    end
    pulse_start(bus.word_in, 1'b1);
    wait_done(1000, ok_d);
    step();
    tests_run++;
    if (!ok_d || bus.dropped !== 1'b1 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL auto_tick_dropped: got done=%b dropped=%b left=%0d expected 1/1/0", ok_d, bus.dropped, sb.size());
    end
    wait_rise(2100, ok, r3);
    push_word(bus.word_in);
    bus.word_in = 32'h13572468;
    tests_run++;
    if (!ok || r3 - r2 != 4000) begin
      tests_failed++;
      $display("FAIL auto_resume: got seen=%b spacing=%0d expected 1/4000", ok, r3 - r2);
    end
    wait_done(1000, ok_d);
    bus.auto_en = 1'b0;
    step();
    tests_run++;
    if (!ok_d || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL auto_last: got done=%b left=%0d expected 1/0", ok_d, sb.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.word_in = 32'h0;
    bus.auto_en = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_dropped();
    test_timeout();
    test_reset_mid();
    test_auto();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
